// File: rtl/systolic_array_ws_pkg.sv
// Shared defaults and FSM state encoding for the weight-stationary systolic array.
package systolic_array_ws_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_A_W  = 8;
    localparam int DEF_W_W  = 8;
    localparam int DEF_P_W  = 32;
    localparam int DEF_LAT  = DEF_ROWS + DEF_COLS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        SWAP  = 2'd3
    } ws_state_e;

endpackage

// File: rtl/systolic_array_ws_pe.sv
// One processing element: registered MAC, shadow/active weight pair and the
// one-cycle hop of the swap wave towards its neighbour.
module systolic_pe
    import systolic_array_ws_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int W_W = DEF_W_W,
    parameter int P_W = DEF_P_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [A_W-1:0] a_i,
    input  logic [P_W-1:0] p_i,
    input  logic           sh_shift_i,
    input  logic [W_W-1:0] sh_i,
    input  logic           swap_i,
    output logic [A_W-1:0] a_o,
    output logic [P_W-1:0] p_o,
    output logic [W_W-1:0] sh_o,
    output logic           swap_o
);

    logic signed [A_W-1:0] a_q;
    logic signed [P_W-1:0] p_q;
    logic signed [P_W-1:0] p_d;
    logic signed [W_W-1:0] sh_q;
    logic signed [W_W-1:0] act_q;
    logic                  swap_q;

    // Product fits exactly in A_W+W_W bits; the accumulate wraps modulo 2^P_W.
    function automatic logic signed [P_W-1:0] mac(
        input logic signed [P_W-1:0] acc,
        input logic signed [A_W-1:0] a,
        input logic signed [W_W-1:0] w
    );
        logic signed [A_W+W_W-1:0] prod;
        prod = a * w;
        return acc + P_W'(prod);
    endfunction

    assign p_d = mac(p_i, a_i, act_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            p_q    <= '0;
            sh_q   <= '0;
            act_q  <= '0;
            swap_q <= 1'b0;
        end else begin
            swap_q <= swap_i;
            if (en_i) begin
                a_q <= a_i;
                p_q <= p_d;
            end
            if (sh_shift_i) begin
                sh_q <= sh_i;
            end
            if (swap_i) begin
                act_q <= sh_q;
            end
        end
    end

    assign a_o    = a_q;
    assign p_o    = p_q;
    assign sh_o   = sh_q;
    assign swap_o = swap_q;

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic array with double-buffered weights,
// a load/swap FSM, and internal input skew / output deskew.
module systolic_array_ws
    import systolic_array_ws_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int A_W  = DEF_A_W,
    parameter int W_W  = DEF_W_W,
    parameter int P_W  = DEF_P_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ROWS*A_W-1:0] in_data,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [COLS*W_W-1:0] w_data,
    input  logic [COLS*P_W-1:0] bias,
    input  logic                switch,
    output logic                switch_ready,
    output logic                out_valid,
    output logic [COLS*P_W-1:0] out_data
);

    localparam int LAT   = ROWS + COLS - 1;
    localparam int CNT_W = $clog2(LAT + 1);

    ws_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_acc;
    logic             sw_acc;

    assign w_acc  = w_valid && w_ready;
    assign sw_acc = switch && switch_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_ready      = 1'b0;
        switch_ready = 1'b0;
        case (state_q)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    state_d = (ROWS == 1) ? READY : LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (cnt_q == CNT_W'(ROWS - 1)) begin
                        state_d = READY;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                switch_ready = 1'b1;
                if (switch) begin
                    state_d = SWAP;
                    cnt_d   = '0;
                end
            end
            SWAP: begin
                // The wave needs LAT edges to reach the far corner PE.
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // vld[k] marks the vector that entered k cycles ago.
    logic [LAT:0] vld;
    logic [LAT:1] vld_q;

    assign vld = {vld_q, in_valid};

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld[LAT-1:0];
        end
    end

    assign out_valid = vld[LAT];

    logic [A_W-1:0] a_bus  [ROWS][COLS+1];
    logic [P_W-1:0] p_bus  [ROWS+1][COLS];
    logic [W_W-1:0] sh_bus [ROWS+1][COLS];
    logic           sw_in  [ROWS][COLS];
    logic           sw_out [ROWS][COLS];

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        if (i == 0) begin : g_noskew
            assign a_bus[0][0] = in_data[A_W-1:0];
        end else begin : g_skew
            logic [A_W-1:0] sk_q [i];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) sk_q[k] <= '0;
                end else begin
                    sk_q[0] <= in_data[i*A_W +: A_W];
                    for (int k = 1; k < i; k++) sk_q[k] <= sk_q[k-1];
                end
            end
            assign a_bus[i][0] = sk_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int DSK = COLS - 1 - j;
        logic [P_W-1:0] bias_smp_q;
        logic [P_W-1:0] bias_act_q;

        // Column 0 switches together with the accepting edge, so it takes bias live.
        always_ff @(posedge clk) begin
            if (!rst) begin
                bias_smp_q <= '0;
                bias_act_q <= '0;
            end else begin
                if (sw_acc) begin
                    bias_smp_q <= bias[j*P_W +: P_W];
                end
                if (sw_in[0][j]) begin
                    bias_act_q <= (j == 0) ? bias[j*P_W +: P_W] : bias_smp_q;
                end
            end
        end

        assign p_bus[0][j]  = bias_act_q;
        assign sh_bus[0][j] = w_data[j*W_W +: W_W];

        if (DSK == 0) begin : g_nodsk
            assign out_data[j*P_W +: P_W] = p_bus[ROWS][j];
        end else begin : g_dsk
            logic [P_W-1:0] dk_q [DSK];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < DSK; k++) dk_q[k] <= '0;
                end else begin
                    if (vld[ROWS+j]) dk_q[0] <= p_bus[ROWS][j];
                    for (int k = 1; k < DSK; k++) begin
                        if (vld[ROWS+j+k]) dk_q[k] <= dk_q[k-1];
                    end
                end
            end
            assign out_data[j*P_W +: P_W] = dk_q[DSK-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_pe_r
        for (genvar j = 0; j < COLS; j++) begin : g_pe_c
            if (j > 0) begin : g_sw_h
                assign sw_in[i][j] = sw_out[i][j-1];
            end else if (i > 0) begin : g_sw_v
                assign sw_in[i][0] = sw_out[i-1][0];
            end else begin : g_sw_0
                assign sw_in[0][0] = sw_acc;
            end

            systolic_pe #(
                .A_W (A_W),
                .W_W (W_W),
                .P_W (P_W)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .en_i       (vld[i+j]),
                .a_i        (a_bus[i][j]),
                .p_i        (p_bus[i][j]),
                .sh_shift_i (w_acc),
                .sh_i       (sh_bus[i][j]),
                .swap_i     (sw_in[i][j]),
                .a_o        (a_bus[i][j+1]),
                .p_o        (p_bus[i+1][j]),
                .sh_o       (sh_bus[i+1][j]),
                .swap_o     (sw_out[i][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws with a behavioural weight/bias model and
// an output scoreboard keyed by expected arrival cycle.
module tb_systolic_array_ws;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int A_W  = 8;
    localparam int W_W  = 8;
    localparam int P_W  = 32;
    localparam int LAT  = ROWS + COLS - 1;
    localparam int OW   = COLS * P_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic [ROWS*A_W-1:0] in_data = '0;
    logic                w_valid = 1'b0;
    logic                w_ready;
    logic [COLS*W_W-1:0] w_data = '0;
    logic [OW-1:0]       bias = '0;
    logic                switch = 1'b0;
    logic                switch_ready;
    logic                out_valid;
    logic [OW-1:0]       out_data;

    always #5 clk = ~clk;

    systolic_array_ws #(
        .ROWS (ROWS), .COLS (COLS), .A_W (A_W), .W_W (W_W), .P_W (P_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .bias         (bias),
        .switch       (switch),
        .switch_ready (switch_ready),
        .out_valid    (out_valid),
        .out_data     (out_data)
    );

    typedef struct {
        logic [OW-1:0] d;
        int            c;
    } exp_t;

    exp_t          sb[$];
    exp_t          e_pop;
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            cyc_n = 0;
    bit            chk_on = 1'b0;
    logic [OW-1:0] last_out = '0;

    logic signed [W_W-1:0] m_sh  [ROWS][COLS];
    logic signed [W_W-1:0] m_act [ROWS][COLS];
    logic signed [P_W-1:0] m_bias [COLS];
    int                    m_st;
    int                    m_cnt;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                m_sh[i][j]  = '0;
                m_act[i][j] = '0;
            end
        for (int j = 0; j < COLS; j++) m_bias[j] = '0;
        m_st  = 0;
        m_cnt = 0;
    endfunction

    function automatic logic [OW-1:0] model_out(input logic [ROWS*A_W-1:0] a);
        logic [OW-1:0]         r;
        logic signed [P_W-1:0] acc;
        for (int j = 0; j < COLS; j++) begin
            acc = m_bias[j];
            for (int i = 0; i < ROWS; i++)
                acc = acc + $signed(a[i*A_W +: A_W]) * m_act[i][j];
            r[j*P_W +: P_W] = acc;
        end
        return r;
    endfunction

    function automatic logic [COLS*W_W-1:0] fill_w(input int v);
        logic [COLS*W_W-1:0] r;
        for (int j = 0; j < COLS; j++) r[j*W_W +: W_W] = W_W'(v);
        return r;
    endfunction

    function automatic logic [COLS*W_W-1:0] row_w(input int k);
        logic [COLS*W_W-1:0] r;
        for (int j = 0; j < COLS; j++) r[j*W_W +: W_W] = W_W'(10*k + j + 1);
        return r;
    endfunction

    function automatic logic [ROWS*A_W-1:0] fill_a(input int v);
        logic [ROWS*A_W-1:0] r;
        for (int i = 0; i < ROWS; i++) r[i*A_W +: A_W] = A_W'(v);
        return r;
    endfunction

    function automatic logic [ROWS*A_W-1:0] ramp_a();
        logic [ROWS*A_W-1:0] r;
        for (int i = 0; i < ROWS; i++) r[i*A_W +: A_W] = A_W'(i + 1);
        return r;
    endfunction

    function automatic logic [OW-1:0] fill_b(input int v, input int step);
        logic [OW-1:0] r;
        for (int j = 0; j < COLS; j++) r[j*P_W +: P_W] = P_W'(v + step*j);
        return r;
    endfunction

    // One clock: check handshake outputs, advance the model, then step the DUT.
    task automatic cyc();
        bit clr;
        clr = 1'b0;
        if (chk_on) begin
            chk("w_ready", w_ready, m_st <= 1);
            chk("switch_ready", switch_ready, m_st == 2);
        end
        if (!rst) begin
            m_reset();
            clr = 1'b1;
        end else begin
            if (in_valid) sb.push_back('{model_out(in_data), cyc_n + LAT});
            if (w_valid && m_st <= 1) begin
                for (int i = ROWS-1; i > 0; i--)
                    for (int j = 0; j < COLS; j++) m_sh[i][j] = m_sh[i-1][j];
                for (int j = 0; j < COLS; j++) m_sh[0][j] = $signed(w_data[j*W_W +: W_W]);
                if (m_st == 0) begin
                    m_st  = (ROWS == 1) ? 2 : 1;
                    m_cnt = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == ROWS) m_st = 2;
                end
            end else if (switch && m_st == 2) begin
                m_act = m_sh;
                for (int j = 0; j < COLS; j++) m_bias[j] = $signed(bias[j*P_W +: P_W]);
                m_st  = 3;
                m_cnt = 0;
            end else if (m_st == 3) begin
                if (m_cnt == LAT-1) m_st = 0;
                else m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        if (clr) begin
            sb.delete();
            last_out = '0;
            chk_on   = 1'b1;
        end
    endtask

    task automatic load_beat(input logic [COLS*W_W-1:0] d);
        w_valid = 1'b1;
        w_data  = d;
        cyc();
        w_valid = 1'b0;
    endtask

    task automatic do_switch(input logic [OW-1:0] b);
        bias   = b;
        switch = 1'b1;
        cyc();
        switch = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4*LAT && sb.size() > 0; k++) cyc();
        chk("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    chk("latency", cyc_n, e_pop.c);
                    chk("out_data", out_data, e_pop.d);
                end
                last_out = out_data;
            end else begin
                chk("out_valid_low", out_valid, 0);
                chk("out_hold", out_data, last_out);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs
        rst = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            w_valid  = 1'($urandom_range(0, 1));
            switch   = 1'($urandom_range(0, 1));
            in_data  = ROWS*A_W'($urandom);
            w_data   = COLS*W_W'($urandom);
            bias     = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_switch_ready", switch_ready, 0);
        in_valid = 1'b0; w_valid = 1'b0; switch = 1'b0;
        in_data = '0; w_data = '0; bias = '0;
        rst = 1'b1;

        // All-1 weights, zero bias, ramp vector
        for (int k = 0; k < ROWS; k++) load_beat(fill_w(1));
        chk("ready_after_load", switch_ready, 1);
        do_switch(fill_b(0, 0));
        repeat (LAT) cyc();
        in_data = ramp_a(); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();
        chk("ramp_const", last_out, {COLS{32'd10}});

        // -128 x -128 corner with bias -5, vectors either side of the swap
        for (int k = 0; k < ROWS; k++) load_beat(fill_w(-128));
        in_data = fill_a(-128); in_valid = 1'b1;
        do_switch(fill_b(-5, 0));
        cyc();
        in_valid = 1'b0;
        drain();
        chk("corner_const", last_out, {COLS{32'd65531}});

        // Continuous stream across two swaps
        in_data = fill_a(1); in_valid = 1'b1;
        for (int k = 0; k < ROWS; k++) load_beat(fill_w(1));
        do_switch(fill_b(0, 0));
        repeat (LAT) cyc();
        for (int k = 0; k < ROWS; k++) load_beat(fill_w(2));
        repeat (2) cyc();
        do_switch(fill_b(0, 0));
        repeat (LAT + 2) cyc();
        in_valid = 1'b0;
        drain();
        chk("stream_const", last_out, {COLS{32'd8}});

        // Ignored switch/weight requests outside their states
        switch = 1'b1; cyc(); switch = 1'b0;
        load_beat(row_w(0));
        load_beat(row_w(1));
        switch = 1'b1; cyc(); switch = 1'b0;
        load_beat(row_w(2));
        load_beat(row_w(3));
        w_valid = 1'b1; w_data = fill_w(99);
        repeat (2) cyc();
        w_valid = 1'b0;
        w_data = fill_w(77);
        do_switch(fill_b(0, 100));
        w_valid = 1'b1;
        repeat (LAT) cyc();
        w_valid = 1'b0;
        in_data = ramp_a(); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();
        chk("ignored_const", last_out, {32'd440, 32'd330, 32'd220, 32'd110});

        // Reset in the middle of a stream
        in_data = fill_a(3); in_valid = 1'b1;
        repeat (4) cyc();
        rst = 1'b0; cyc(); rst = 1'b1;
        in_valid = 1'b0;
        chk("midstream_rst_out_valid", out_valid, 0);
        chk("midstream_rst_out_data", out_data, 0);

        // Reset in the middle of a swap, then compute with cleared weights
        for (int k = 0; k < ROWS; k++) load_beat(fill_w(1));
        in_data = fill_a(2); in_valid = 1'b1;
        do_switch(fill_b(7, 0));
        repeat (3) cyc();
        rst = 1'b0; cyc(); rst = 1'b1;
        in_valid = 1'b0;
        chk("midswap_rst_out_valid", out_valid, 0);
        chk("midswap_rst_w_ready", w_ready, 1);
        chk("midswap_rst_switch_ready", switch_ready, 0);
        in_data = fill_a(5); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();
        chk("post_rst_zero", last_out, 0);

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
